// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared compute-unit types: command/response buffer lines, buffer status
// and the read-command arbiter state encoding.
package cu_pkg;

  localparam int CU_ID_W = 8;
  localparam int CU_READ_ARB_MAX_OUTSTANDING = 32;

  typedef struct packed {
    logic               valid;
    logic [CU_ID_W-1:0] cu_id;
    logic [15:0]        tag;
    logic [63:0]        address;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
    logic [1:0]       response;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } ArbiterState;

endpackage

// File: rtl/cu_read_command_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQUESTORS.
module round_robin_priority_arbiter #(
  parameter int NUM_REQUESTORS = 4,
  localparam int PTR_W = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1
)(
  input  logic [NUM_REQUESTORS-1:0] request_i,
  input  logic [PTR_W-1:0]          ptr_i,
  output logic [NUM_REQUESTORS-1:0] grant_o
);

  int         idx;
  logic [PTR_W-1:0] sel;

  // Scan farthest-first so the nearest requester overwrites earlier picks.
  always_comb begin
    grant_o = '0;
    idx     = 0;
    sel     = '0;
    for (int k = NUM_REQUESTORS - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQUESTORS) idx = idx - NUM_REQUESTORS;
      sel = PTR_W'(idx);
      if (request_i[sel]) begin
        grant_o      = '0;
        grant_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Round-robin read-command arbiter with global credit limit, per-CU
// outstanding tracking and an idle/active/drain handshake.
module cu_read_command_arbiter
  import cu_pkg::*;
#(
  parameter int NUM_REQUESTORS  = 4,
  parameter int MAX_OUTSTANDING = CU_READ_ARB_MAX_OUTSTANDING,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
)(
  input  logic                                clock,
  input  logic                                rst,
  input  logic                                enabled_in,
  input  logic [NUM_REQUESTORS-1:0]           request_in,
  input  CommandBufferLine [NUM_REQUESTORS-1:0] command_in,
  output logic [NUM_REQUESTORS-1:0]           grant_out,
  input  BufferStatus                         command_buffer_status,
  input  ResponseBufferLine                   read_response_in,
  output CommandBufferLine                    command_out,
  output logic [CNT_W-1:0]                    outstanding_count,
  output logic [NUM_REQUESTORS-1:0]           requester_idle_out,
  output logic                                drained_out,
  output logic                                error_out
);

  localparam int PTR_W = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1;
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CU_ID_W-1:0] NUM_ID  = CU_ID_W'(NUM_REQUESTORS);

  ArbiterState state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [NUM_REQUESTORS-1:0][CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [NUM_REQUESTORS-1:0] idle_q, idle_d;
  logic err_q, err_d;
  CommandBufferLine cmd_q, cmd_d;

  logic [NUM_REQUESTORS-1:0] arb_grant;
  logic [PTR_W-1:0]          winner;
  CommandBufferLine          win_cmd;
  logic                      issue;
  logic                      resp_v;
  logic [CU_ID_W-1:0]        resp_id;
  logic                      bad_id;
  logic                      g_under;
  logic                      r_under;

  round_robin_priority_arbiter #(
    .NUM_REQUESTORS(NUM_REQUESTORS)
  ) u_rr (
    .request_i(request_in),
    .ptr_i    (ptr_q),
    .grant_o  (arb_grant)
  );

  assign resp_v  = read_response_in.valid;
  assign resp_id = read_response_in.cmd.cu_id;
  assign bad_id  = resp_v && (resp_id >= NUM_ID);

  // Credit check uses the registered count, so a freed credit is usable
  // only on the following cycle.
  assign issue = (state_q == ACTIVE) && enabled_in &&
                 !command_buffer_status.alfull &&
                 (out_cnt_q < MAX_CNT) && (|request_in);

  assign grant_out = issue ? arb_grant : '0;

  always_comb begin
    winner  = '0;
    win_cmd = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (arb_grant[i]) begin
        winner  = PTR_W'(i);
        win_cmd = command_in[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cmd_d = '0;
    if (issue) begin
      ptr_d = (winner == PTR_W'(NUM_REQUESTORS - 1)) ?
              '0 : winner + PTR_W'(1);
      cmd_d       = win_cmd;
      cmd_d.valid = 1'b1;
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    g_under   = 1'b0;
    unique case ({issue, resp_v})
      2'b10: out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01: begin
        if (out_cnt_q == '0) g_under = 1'b1;
        else out_cnt_d = out_cnt_q - CNT_W'(1);
      end
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_comb begin
    req_cnt_d = req_cnt_q;
    idle_d    = '0;
    r_under   = 1'b0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (issue && arb_grant[i] &&
          !(resp_v && resp_id == CU_ID_W'(i))) begin
        req_cnt_d[i] = req_cnt_q[i] + CNT_W'(1);
      end else if (resp_v && resp_id == CU_ID_W'(i) &&
                   !(issue && arb_grant[i])) begin
        if (req_cnt_q[i] == '0) r_under = 1'b1;
        else req_cnt_d[i] = req_cnt_q[i] - CNT_W'(1);
      end
      idle_d[i] = (req_cnt_d[i] == '0);
    end
  end

  assign err_d = err_q | g_under | r_under | bad_id;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enabled_in) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enabled_in) state_d = (out_cnt_q == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enabled_in) state_d = ACTIVE;
        else if (out_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      out_cnt_q <= '0;
      req_cnt_q <= '0;
      idle_q    <= '1;
      err_q     <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_cnt_q <= out_cnt_d;
      req_cnt_q <= req_cnt_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
    end
  end

  assign command_out        = cmd_q;
  assign outstanding_count  = out_cnt_q;
  assign requester_idle_out = idle_q;
  assign drained_out        = (state_q == IDLE);
  assign error_out          = err_q;

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Randomized and directed bench for cu_read_command_arbiter against a
// cycle-level reference model of the arbitration and counting rules.
module tb_cu_read_command_arbiter;
  import cu_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic enabled_in;
  logic [N-1:0] request_in;
  CommandBufferLine [N-1:0] command_in;
  logic [N-1:0] grant_out;
  BufferStatus command_buffer_status;
  ResponseBufferLine read_response_in;
  CommandBufferLine command_out;
  logic [CW-1:0] outstanding_count;
  logic [N-1:0] requester_idle_out;
  logic drained_out;
  logic error_out;

  cu_read_command_arbiter #(
    .NUM_REQUESTORS (N),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock                (clock),
    .rst                  (rst),
    .enabled_in           (enabled_in),
    .request_in           (request_in),
    .command_in           (command_in),
    .grant_out            (grant_out),
    .command_buffer_status(command_buffer_status),
    .read_response_in     (read_response_in),
    .command_out          (command_out),
    .outstanding_count    (outstanding_count),
    .requester_idle_out   (requester_idle_out),
    .drained_out          (drained_out),
    .error_out            (error_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = active, 2 = drain
  int m_state;
  int m_out;
  int m_ptr;
  int m_cnt[N];
  bit m_err;
  CommandBufferLine m_cmd;

  function automatic void m_reset();
    m_state = 0;
    m_out   = 0;
    m_ptr   = 0;
    m_err   = 1'b0;
    m_cmd   = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic int m_winner();
    if (m_state != 1 || !enabled_in || command_buffer_status.alfull ||
        m_out >= MAXO || request_in == '0) return -1;
    for (int k = 0; k < N; k++)
      if (request_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_grant();
    int w;
    w = m_winner();
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  function automatic logic [N-1:0] m_idle();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] == 0);
    return v;
  endfunction

  function automatic CommandBufferLine rand_cmd(int id);
    CommandBufferLine c;
    c         = '0;
    c.valid   = 1'($urandom % 2);
    c.cu_id   = CU_ID_W'(id);
    c.tag     = 16'($urandom);
    c.address = {$urandom, $urandom};
    return c;
  endfunction

  function automatic ResponseBufferLine resp(int id);
    ResponseBufferLine r;
    r           = '0;
    r.valid     = 1'b1;
    r.cmd.cu_id = CU_ID_W'(id);
    return r;
  endfunction

  // Advance one clock edge, applying the spec rules to the model.
  task automatic step();
    int w;
    int rid;
    bit rv;
    bit inc;
    bit dec;
    @(posedge clock);
    w   = m_winner();
    rv  = read_response_in.valid;
    rid = int'(read_response_in.cmd.cu_id);
    case (m_state)
      0: if (enabled_in) m_state = 1;
      1: if (!enabled_in) m_state = (m_out == 0) ? 0 : 2;
      default: begin
        if (enabled_in) m_state = 1;
        else if (m_out == 0) m_state = 0;
      end
    endcase
    if (w >= 0) begin
      m_cmd       = command_in[w];
      m_cmd.valid = 1'b1;
      m_ptr       = (w + 1) % N;
    end else begin
      m_cmd = '0;
    end
    if (w >= 0 && !rv) m_out++;
    else if (rv && w < 0) begin
      if (m_out == 0) m_err = 1'b1;
      else m_out--;
    end
    if (rv && rid >= N) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      inc = (w == i);
      dec = rv && (rid == i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i]--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst                   = 1'b1;
    enabled_in            = 1'b0;
    request_in            = '0;
    command_in            = '0;
    command_buffer_status = '0;
    read_response_in      = '0;
    @(posedge clock);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant_out !== '0) begin
      errors++;
      $display("FAIL reset_grant: got %b expected 0", grant_out);
    end
    checks++;
    if (command_out !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got %h expected 0", command_out);
    end
    checks++;
    if (outstanding_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", outstanding_count);
    end
    checks++;
    if (requester_idle_out !== '1) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 1111", requester_idle_out);
    end
    checks++;
    if (drained_out !== 1'b1 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got drained=%b err=%b expected 1 0",
               drained_out, error_out);
    end
  endtask

  task automatic test_single_requester();
    CommandBufferLine c;
    CommandBufferLine exp;
    do_reset();
    enabled_in = 1'b1;
    step();
    c             = rand_cmd(0);
    command_in[0] = c;
    request_in    = 4'b0001;
    #1;
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0001", grant_out);
    end
    step();
    request_in = '0;
    exp        = c;
    exp.valid  = 1'b1;
    checks++;
    if (command_out !== exp) begin
      errors++;
      $display("FAIL single_cmd: got %h expected %h", command_out, exp);
    end
    checks++;
    if (outstanding_count !== CW'(1) || requester_idle_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got cnt=%0d idle0=%b expected 1 0",
               outstanding_count, requester_idle_out[0]);
    end
    read_response_in = resp(0);
    step();
    read_response_in = '0;
    checks++;
    if (outstanding_count !== '0 || requester_idle_out[0] !== 1'b1 ||
        command_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got cnt=%0d idle0=%b v=%b expected 0 1 0",
               outstanding_count, requester_idle_out[0], command_out.valid);
    end
  endtask

  task automatic test_fairness();
    int exp_seq[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
    do_reset();
    enabled_in = 1'b1;
    step();
    for (int i = 0; i < N; i++) command_in[i] = rand_cmd(i);
    request_in = '1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) request_in = 4'b1010;
      #1;
      checks++;
      if (grant_out !== 4'(1 << exp_seq[k])) begin
        errors++;
        $display("FAIL fairness_%0d: got %b expected %b",
                 k, grant_out, 4'(1 << exp_seq[k]));
      end
      step();
      read_response_in = resp(exp_seq[k]);
    end
    request_in = '0;
    step();
    read_response_in = '0;
    checks++;
    if (outstanding_count !== '0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL fairness_end: got cnt=%0d err=%b expected 0 0",
               outstanding_count, error_out);
    end
  endtask

  task automatic test_credit_limit();
    int n;
    do_reset();
    enabled_in = 1'b1;
    step();
    request_in = '1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (grant_out != '0) n++;
      step();
    end
    checks++;
    if (n != MAXO || outstanding_count !== CW'(MAXO)) begin
      errors++;
      $display("FAIL credit_fill: got issues=%0d cnt=%0d expected 4 4",
               n, outstanding_count);
    end
    read_response_in = resp(0);
    #1;
    checks++;
    if (grant_out !== '0) begin
      errors++;
      $display("FAIL credit_full_grant: got %b expected 0", grant_out);
    end
    step();
    read_response_in = '0;
    #1;
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL credit_release: got %b expected 0001", grant_out);
    end
    step();
    #1;
    checks++;
    if (grant_out !== '0 || outstanding_count !== CW'(MAXO)) begin
      errors++;
      $display("FAIL credit_refill: got g=%b cnt=%0d expected 0 4",
               grant_out, outstanding_count);
    end
    request_in       = '0;
    read_response_in = resp(1);
    step();
    request_in       = '1;
    read_response_in = resp(2);
    #1;
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL simul_grant: got %b expected 0010", grant_out);
    end
    step();
    checks++;
    if (outstanding_count !== CW'(3)) begin
      errors++;
      $display("FAIL simul_count: got %0d expected 3", outstanding_count);
    end
    request_in       = '0;
    read_response_in = resp(7);
    step();
    read_response_in = '0;
    checks++;
    if (outstanding_count !== CW'(2) || error_out !== 1'b1) begin
      errors++;
      $display("FAIL bad_id: got cnt=%0d err=%b expected 2 1",
               outstanding_count, error_out);
    end
  endtask

  task automatic test_backpressure_drain();
    do_reset();
    enabled_in = 1'b1;
    step();
    command_buffer_status.alfull = 1'b1;
    request_in = '1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (grant_out !== '0) begin
        errors++;
        $display("FAIL alfull_%0d: got %b expected 0", k, grant_out);
      end
      step();
    end
    command_buffer_status.alfull = 1'b0;
    for (int k = 0; k < 3; k++) step();
    request_in = '0;
    enabled_in = 1'b0;
    step();
    checks++;
    if (outstanding_count !== CW'(3) || drained_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: got cnt=%0d drained=%b expected 3 0",
               outstanding_count, drained_out);
    end
    for (int k = 0; k < 3; k++) begin
      read_response_in = resp(k);
      step();
    end
    read_response_in = '0;
    step();
    checks++;
    if (outstanding_count !== '0 || drained_out !== 1'b1 ||
        error_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: got cnt=%0d drained=%b err=%b expected 0 1 0",
               outstanding_count, drained_out, error_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enabled_in = 1'b1;
    step();
    request_in = '1;
    step();
    step();
    checks++;
    if (outstanding_count !== CW'(2)) begin
      errors++;
      $display("FAIL areset_pre: got %0d expected 2", outstanding_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outstanding_count !== '0 || requester_idle_out !== '1 ||
        drained_out !== 1'b1 || command_out !== '0 ||
        grant_out !== '0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL areset: got cnt=%0d idle=%b dr=%b cmd=%h g=%b err=%b",
               outstanding_count, requester_idle_out, drained_out,
               command_out, grant_out, error_out);
    end
    do_reset();
  endtask

  task automatic test_random();
    int start;
    int id;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enabled_in = ($urandom % 8) != 0;
      command_buffer_status.alfull = ($urandom % 4) == 0;
      request_in = N'($urandom);
      for (int i = 0; i < N; i++) command_in[i] = rand_cmd(i);
      read_response_in = '0;
      if ($urandom % 2 == 1) begin
        start = int'($urandom % N);
        id = -1;
        for (int k = N - 1; k >= 0; k--)
          if (m_cnt[(start + k) % N] > 0) id = (start + k) % N;
        if (id >= 0) read_response_in = resp(id);
      end
      #1;
      checks++;
      if (grant_out !== m_grant()) begin
        errors++;
        $display("FAIL rand_grant@%0d: got %b expected %b",
                 cyc, grant_out, m_grant());
      end
      step();
      checks++;
      if (command_out !== m_cmd) begin
        errors++;
        $display("FAIL rand_cmd@%0d: got %h expected %h",
                 cyc, command_out, m_cmd);
      end
      checks++;
      if (outstanding_count !== CW'(m_out)) begin
        errors++;
        $display("FAIL rand_count@%0d: got %0d expected %0d",
                 cyc, outstanding_count, m_out);
      end
      checks++;
      if (requester_idle_out !== m_idle()) begin
        errors++;
        $display("FAIL rand_idle@%0d: got %b expected %b",
                 cyc, requester_idle_out, m_idle());
      end
      checks++;
      if (drained_out !== (m_state == 0) || error_out !== m_err) begin
        errors++;
        $display("FAIL rand_flags@%0d: got dr=%b err=%b expected %b %b",
                 cyc, drained_out, error_out, m_state == 0, m_err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_requester();
    test_fairness();
    test_credit_limit();
    test_backpressure_drain();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
